// File: rtl/decoder_grant_arbiter.sv
// Four-requester round-robin arbiter driving the select pair of a 2-to-4
// active-low decoder, with a bounded hold time and one idle cycle between grants.
//
// state | meaning
// IDLE  | no owner; gnt_n all high, s1:s0 keep the last granted index
// GRANT | agent s1:s0 owns the decoder; hold_cnt counts visible grant cycles
module decoder_grant_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic       s0,
    output logic       s1,
    output logic [3:0] gnt_n,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [1:0]         sel, sel_nx;
    logic [1:0]         last_ptr, last_ptr_nx;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nx;
    logic [3:0]         gnt_n_nx;
    logic               busy_nx, timeout_nx;
    logic [1:0]         winner, cand;
    logic               found;

    assign s0 = sel[0];
    assign s1 = sel[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 2'd0;
            last_ptr <= 2'd3;
            hold_cnt <= '0;
            gnt_n    <= 4'b1111;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            last_ptr <= last_ptr_nx;
            hold_cnt <= hold_cnt_nx;
            gnt_n    <= gnt_n_nx;
            busy     <= busy_nx;
            timeout  <= timeout_nx;
        end
    end

    // Scan starts just past the last owner; k=4 wraps back onto last_ptr itself,
    // so the previous owner is considered last.
    always_comb begin
        winner = last_ptr;
        found  = 1'b0;
        cand   = last_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = last_ptr + 2'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        sel_nx      = sel;
        last_ptr_nx = last_ptr;
        hold_cnt_nx = hold_cnt;
        gnt_n_nx    = gnt_n;
        busy_nx     = busy;
        timeout_nx  = 1'b0;
        case (state)
            IDLE: begin
                gnt_n_nx = 4'b1111;
                busy_nx  = 1'b0;
                if (|req) begin
                    state_nx    = GRANT;
                    sel_nx      = winner;
                    gnt_n_nx    = ~(4'b0001 << winner);
                    busy_nx     = 1'b1;
                    hold_cnt_nx = CNT_W'(1);
                end
            end
            GRANT: begin
                // Owner release wins over the hold limit, so timeout stays low then.
                if (!req[sel] || (hold_cnt == CNT_W'(HOLD_MAX))) begin
                    state_nx    = IDLE;
                    gnt_n_nx    = 4'b1111;
                    busy_nx     = 1'b0;
                    last_ptr_nx = sel;
                    hold_cnt_nx = '0;
                    timeout_nx  = req[sel];
                end else begin
                    hold_cnt_nx = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Scoreboard bench for decoder_grant_arbiter: a cycle-level reference model
// queues expected outputs each clock, a monitor compares on the falling edge.
module tb_decoder_grant_arbiter;

    localparam int HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b1111;
    logic       s0, s1, busy, timeout;
    logic [3:0] gnt_n;
    logic [3:0] dec_d;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] gnt_n;
        logic [1:0] sel;
        logic       busy;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];

    decoder_grant_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .s0      (s0),
        .s1      (s1),
        .gnt_n   (gnt_n),
        .busy    (busy),
        .timeout (timeout)
    );

    // The shared decoder as seen by the agents
    assign dec_d = ~(4'b0001 << {s1, s0});

    always #5 clk = ~clk;

    // Reference model: owner is -1 when nobody holds the resource.
    initial begin
        int   owner, cnt, last, selm;
        bit   to;
        exp_t e;
        owner = -1; cnt = 0; last = 3; selm = 0; to = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                owner = -1; cnt = 0; last = 3; selm = 0; to = 0;
            end else begin
                to = 0;
                if (owner < 0) begin
                    if (req != 4'b0000) begin
                        for (int k = 1; k <= 4; k++) begin
                            if (req[(last + k) % 4]) begin
                                owner = (last + k) % 4;
                                break;
                            end
                        end
                        selm = owner;
                        cnt  = 1;
                    end
                end else if (!req[owner]) begin
                    last = owner; owner = -1; cnt = 0;
                end else if (cnt == HOLD_MAX) begin
                    last = owner; owner = -1; cnt = 0; to = 1;
                end else begin
                    cnt++;
                end
            end
            e.gnt_n   = (owner < 0) ? 4'b1111 : ~(4'b0001 << owner);
            e.sel     = 2'(selm);
            e.busy    = (owner >= 0);
            e.timeout = to;
            exp_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (gnt_n !== e.gnt_n || {s1, s0} !== e.sel || busy !== e.busy || timeout !== e.timeout) begin
                    fails++;
                    $display("FAIL scoreboard t=%0t: got gnt_n=%b sel=%b busy=%b to=%b, exp gnt_n=%b sel=%b busy=%b to=%b",
                             $time, gnt_n, {s1, s0}, busy, timeout, e.gnt_n, e.sel, e.busy, e.timeout);
                end
                if (busy === 1'b1) begin
                    tests++;
                    if (dec_d !== gnt_n) begin
                        fails++;
                        $display("FAIL decoder t=%0t: got d=%b, exp gnt_n=%b", $time, dec_d, gnt_n);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t: got %h, exp %h", name, $time, got, exp);
        end
    endtask

    task automatic wait_busy(input string name);
        bit ok;
        ok = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk); #1;
            if (busy) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got no grant within 12 cycles, exp busy=1", name);
        end
    endtask

    function automatic int owner_of(input logic [3:0] g);
        int o;
        o = -1;
        for (int b = 0; b < 4; b++) if (!g[b]) o = b;
        return o;
    endfunction

    initial begin
        int exp_order[5];
        int own, cnt;
        exp_order = '{0, 1, 2, 3, 0};

        // Reset held with every agent requesting
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {gnt_n, s1, s0, busy, timeout}, {4'b1111, 4'b0000});
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0000;
        @(negedge clk);

        // Single requester
        req = 4'b0001;
        @(negedge clk); #1;
        check("single_grant", {gnt_n, s1, s0, busy, 1'b0}, {4'b1110, 2'b00, 1'b1, 1'b0});
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk); #1;
        check("single_release", {3'b000, gnt_n, busy}, {3'b000, 4'b1111, 1'b0});

        // Asynchronous reset in the middle of a grant
        req = 4'b1000;
        wait_busy("grant_before_reset");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {3'b000, gnt_n, busy}, {3'b000, 4'b1111, 1'b0});
        @(negedge clk);
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin order from reset with everyone requesting
        for (int i = 0; i < 5; i++) begin
            wait_busy("rr_grant");
            own = owner_of(gnt_n);
            check("rr_order", 8'(own), 8'(exp_order[i]));
            @(negedge clk);
            if (own >= 0) req[own] = 1'b0;
            @(negedge clk);
            req = 4'b1111;
        end
        @(negedge clk);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Hold limit on a lone requester
        req = 4'b0100;
        wait_busy("to_grant");
        cnt = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (gnt_n == 4'b1011) cnt++;
            else break;
        end
        check("to_length", 8'(cnt), 8'(HOLD_MAX));
        check("to_pulse", {6'b0, timeout, busy}, 8'b0000_0010);
        @(negedge clk); #1;
        check("to_regrant", {4'b0000, gnt_n}, {4'b0000, 4'b1011});
        req = 4'b0110;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (timeout) break;
        end
        wait_busy("to_next");
        check("to_next_owner", {4'b0000, gnt_n}, {4'b0000, 4'b1101});
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Non-owner request cannot preempt
        req = 4'b1000;
        wait_busy("np_grant");
        @(negedge clk);
        req = 4'b1001;
        repeat (3) @(negedge clk);
        #1 check("no_preempt", {4'b0000, gnt_n}, {4'b0000, 4'b0111});
        req = 4'b0001;
        repeat (3) @(negedge clk);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Owner drops on the same edge the hold limit is reached
        req = 4'b0010;
        wait_busy("rl_grant");
        repeat (HOLD_MAX - 1) @(negedge clk);
        req = 4'b0000;
        @(negedge clk); #1;
        check("release_at_limit", {6'b0, busy, timeout}, 8'h00);

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, exp finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
